// File: rtl/mmio_counter_ctrl.sv
// mmio_counter_ctrl: MMIO-mapped cycle / retired-instruction counters with a
// RUN / FROZEN / ARMED mode FSM and an atomic two-register snapshot.
//
// Build option: define BP_CNTR_EN to add the branch-total and branch-correct
// counters at offsets 0x1C / 0x20. Without it those offsets read 0 and the
// branch retire inputs are ignored.
//
// Handshake: mmio_we / mmio_re are single-cycle strobes with no back-pressure;
// a store takes effect at the edge that samples mmio_we, and load data appears
// on mmio_rdata the cycle after mmio_re and holds until the next mmio_re.
module mmio_counter_ctrl #(
    parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
    parameter int          CNTR_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mmio_addr,
    input  logic [31:0] mmio_wdata,
    input  logic        mmio_we,
    input  logic        mmio_re,
    output logic [31:0] mmio_rdata,
    input  logic        inst_retire,
    input  logic        br_retire,
    input  logic        br_correct,
    output logic [1:0]  cntr_mode
);

    typedef enum logic [1:0] {
        S_RUN    = 2'b00,
        S_FROZEN = 2'b01,
        S_ARMED  = 2'b10
    } mode_t;

    localparam logic [7:0] OFF_CYCLE  = 8'h10;
    localparam logic [7:0] OFF_INSTR  = 8'h14;
    localparam logic [7:0] OFF_CLEAR  = 8'h18;
    localparam logic [7:0] OFF_BRTOT  = 8'h1C;
    localparam logic [7:0] OFF_BRCOR  = 8'h20;
    localparam logic [7:0] OFF_CTRL   = 8'h30;
    localparam logic [7:0] OFF_STATUS = 8'h34;
    localparam logic [7:0] OFF_SNAP   = 8'h38;
    localparam logic [7:0] OFF_SCYCLE = 8'h3C;
    localparam logic [7:0] OFF_SINSTR = 8'h40;

    localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);

    mode_t                  state;
    logic [CNTR_WIDTH-1:0]  cycle_cnt;
    logic [CNTR_WIDTH-1:0]  instr_cnt;
    logic [CNTR_WIDTH-1:0]  snap_cycle;
    logic [CNTR_WIDTH-1:0]  snap_instr;
    logic [CNTR_WIDTH-1:0]  br_total_cnt;
    logic [CNTR_WIDTH-1:0]  br_correct_cnt;

    logic        hit;
    logic [7:0]  offset;
    logic        wr_clear;
    logic        wr_ctrl;
    logic        wr_snap;
    logic        count_en;
    logic [31:0] rd_next;

    // Zero-extend a counter value onto the 32-bit read bus.
    function automatic logic [31:0] ext(input logic [CNTR_WIDTH-1:0] v);
        logic [31:0] r;
        r = '0;
        r[CNTR_WIDTH-1:0] = v;
        return r;
    endfunction

    // Word-aligned decode inside the 256-byte window at ADDR_BASE.
    assign hit      = (mmio_addr[31:8] == ADDR_BASE[31:8]);
    assign offset   = {mmio_addr[7:2], 2'b00};
    assign wr_clear = mmio_we && hit && (offset == OFF_CLEAR);
    assign wr_ctrl  = mmio_we && hit && (offset == OFF_CTRL);
    assign wr_snap  = mmio_we && hit && (offset == OFF_SNAP);

    // The arming retire counts in the same cycle it releases ARMED.
    assign count_en = (state == S_RUN) || ((state == S_ARMED) && inst_retire);

    assign cntr_mode = state;

    // Mode FSM: control writes win; otherwise ARMED leaves on the first retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RUN;
        end else if (wr_ctrl) begin
            case (mmio_wdata[1:0])
                2'd0:    state <= S_RUN;
                2'd1:    state <= S_FROZEN;
                2'd2:    state <= S_ARMED;
                default: state <= state;
            endcase
        end else if ((state == S_ARMED) && inst_retire) begin
            state <= S_RUN;
        end
    end

    // Live cycle / instruction counters; clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (wr_clear) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (count_en) begin
            cycle_cnt <= cycle_cnt + CNT_ONE;
            if (inst_retire) begin
                instr_cnt <= instr_cnt + CNT_ONE;
            end
        end
    end

    // Snapshot shadows capture the pre-increment live pair in one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_cycle <= '0;
            snap_instr <= '0;
        end else if (wr_snap) begin
            snap_cycle <= cycle_cnt;
            snap_instr <= instr_cnt;
        end
    end

`ifdef BP_CNTR_EN
    // Branch counters follow the same enable and clear as the live pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_total_cnt   <= '0;
            br_correct_cnt <= '0;
        end else if (wr_clear) begin
            br_total_cnt   <= '0;
            br_correct_cnt <= '0;
        end else if (count_en && br_retire) begin
            br_total_cnt <= br_total_cnt + CNT_ONE;
            if (br_correct) begin
                br_correct_cnt <= br_correct_cnt + CNT_ONE;
            end
        end
    end
`else
    assign br_total_cnt   = '0;
    assign br_correct_cnt = '0;
    logic unused_br;
    assign unused_br = br_retire ^ br_correct ^ (^br_total_cnt) ^ (^br_correct_cnt);
`endif

    logic unused_bits;
    assign unused_bits = ^{mmio_addr[1:0], mmio_wdata[31:2]};

    // Read mux: readable offsets only; everything else returns zero.
    always_comb begin
        rd_next = '0;
        if (hit) begin
            case (offset)
                OFF_CYCLE:  rd_next = ext(cycle_cnt);
                OFF_INSTR:  rd_next = ext(instr_cnt);
`ifdef BP_CNTR_EN
                OFF_BRTOT:  rd_next = ext(br_total_cnt);
                OFF_BRCOR:  rd_next = ext(br_correct_cnt);
`endif
                OFF_STATUS: rd_next = {30'd0, state};
                OFF_SCYCLE: rd_next = ext(snap_cycle);
                OFF_SINSTR: rd_next = ext(snap_instr);
                default:    rd_next = '0;
            endcase
        end
    end

    // Registered load data, updated only on a load strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mmio_rdata <= '0;
        end else if (mmio_re) begin
            mmio_rdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_mmio_counter_ctrl.sv
// Self-checking bench for mmio_counter_ctrl, built with an 8-bit counter width
// so the wrap-around case is reachable in a few hundred cycles.
module tb_mmio_counter_ctrl;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          W    = 8;
`ifdef BP_CNTR_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic        mmio_we;
    logic        mmio_re;
    logic [31:0] mmio_rdata;
    logic        inst_retire;
    logic        br_retire;
    logic        br_correct;
    logic [1:0]  cntr_mode;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[8];

    mmio_counter_ctrl #(.ADDR_BASE(BASE), .CNTR_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
        .mmio_we(mmio_we), .mmio_re(mmio_re), .mmio_rdata(mmio_rdata),
        .inst_retire(inst_retire), .br_retire(br_retire), .br_correct(br_correct),
        .cntr_mode(cntr_mode)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        mmio_addr  = addr;
        mmio_wdata = data;
        mmio_we    = 1'b1;
        tick();
        mmio_we    = 1'b0;
        mmio_wdata = $urandom;
    endtask

    // Load: push expectation at issue, pop and compare when data returns.
    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        logic [31:0] e;
        string       n;
        mmio_addr = addr;
        mmio_re   = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        tick();
        mmio_re = 1'b0;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, mmio_rdata, e);
    endtask

    initial begin
        rst_n       = 1'b0;
        mmio_addr   = '0;
        mmio_wdata  = '0;
        mmio_we     = 1'b0;
        mmio_re     = 1'b0;
        inst_retire = 1'b0;
        br_retire   = 1'b0;
        br_correct  = 1'b0;

        vecs[0] = '{BASE + 32'h30,  32'd1, BASE + 32'h34, 32'd1, "ctrl_frozen"};
        vecs[1] = '{BASE + 32'h30,  32'd0, BASE + 32'h34, 32'd0, "ctrl_run"};
        vecs[2] = '{BASE + 32'h30,  32'd2, BASE + 32'h34, 32'd2, "ctrl_armed"};
        vecs[3] = '{BASE + 32'h30,  32'd3, BASE + 32'h34, 32'd2, "ctrl_3_ignored"};
        vecs[4] = '{BASE + 32'h30,  32'd1, BASE + 32'h34, 32'd1, "ctrl_armed_to_frozen"};
        vecs[5] = '{BASE + 32'h130, 32'd0, BASE + 32'h34, 32'd1, "ctrl_wrong_base"};
        vecs[6] = '{BASE + 32'h34,  32'd0, BASE + 32'h34, 32'd1, "write_ro_ignored"};
        vecs[7] = '{BASE + 32'h33,  32'd0, BASE + 32'h37, 32'd0, "ctrl_low_bits_ignored"};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdata", mmio_rdata, 32'd0);
        check("reset_mode", {30'd0, cntr_mode}, 32'd0);
        rst_n = 1'b1;

        // Free-running cycle count and zero reads
        repeat (10) tick();
        rd(BASE + 32'h10, 32'd10, "cycle_after_10");
        rd(BASE + 32'h14, 32'd0, "instr_idle");
        rd(BASE + 32'h34, 32'd0, "status_run");
        rd(BASE + 32'h18, 32'd0, "read_clear_wo");
        rd(BASE + 32'h38, 32'd0, "read_snap_wo");
        rd(BASE + 32'h44, 32'd0, "read_unmapped");
        rd(BASE + 32'h110, 32'd0, "read_wrong_base");

        // Control / decode table
        for (int i = 0; i < 8; i++) begin
            wr(vecs[i].waddr, vecs[i].wdata);
            rd(vecs[i].raddr, vecs[i].exp, vecs[i].name);
        end

        // Clear then 10 retires
        wr(BASE + 32'h18, 32'hFFFF_FFFF);
        inst_retire = 1'b1;
        repeat (10) tick();
        inst_retire = 1'b0;
        rd(BASE + 32'h14, 32'd10, "instr_10");
        rd(BASE + 32'h10, 32'd11, "cycle_after_clear");
        inst_retire = 1'b1;
        wr(BASE + 32'h18, 32'd0);
        inst_retire = 1'b0;
        rd(BASE + 32'h14, 32'd0, "clear_beats_retire");

        // Freeze at 5, resume
        wr(BASE + 32'h18, 32'd0);
        repeat (4) tick();
        wr(BASE + 32'h30, 32'd1);
        inst_retire = 1'b1;
        repeat (20) tick();
        inst_retire = 1'b0;
        rd(BASE + 32'h10, 32'd5, "frozen_cycle");
        rd(BASE + 32'h14, 32'd0, "frozen_instr");
        wr(BASE + 32'h30, 32'd0);
        rd(BASE + 32'h10, 32'd5, "resume_edge");
        rd(BASE + 32'h10, 32'd6, "resume_next");

        // Armed: hold until first retire, which counts
        wr(BASE + 32'h30, 32'd2);
        wr(BASE + 32'h18, 32'd0);
        repeat (5) tick();
        rd(BASE + 32'h34, 32'd2, "status_armed");
        rd(BASE + 32'h10, 32'd0, "armed_hold");
        inst_retire = 1'b1;
        tick();
        inst_retire = 1'b0;
        rd(BASE + 32'h10, 32'd1, "armed_cycle");
        rd(BASE + 32'h14, 32'd1, "armed_instr");
        rd(BASE + 32'h34, 32'd0, "armed_to_run");

        // Wrap at 2^W
        wr(BASE + 32'h18, 32'd0);
        repeat (254) tick();
        rd(BASE + 32'h10, 32'd254, "wrap_fe");
        rd(BASE + 32'h10, 32'd255, "wrap_ff");
        rd(BASE + 32'h10, 32'd0, "wrap_zero");

        // Snapshot at cycle 100
        wr(BASE + 32'h18, 32'd0);
        inst_retire = 1'b1;
        repeat (7) tick();
        inst_retire = 1'b0;
        repeat (93) tick();
        wr(BASE + 32'h38, 32'd0);
        repeat (10) tick();
        rd(BASE + 32'h3C, 32'd100, "snap_cycle");
        rd(BASE + 32'h10, 32'd112, "live_cycle_after_snap");
        rd(BASE + 32'h40, 32'd7, "snap_instr");
        rd(BASE + 32'h14, 32'd7, "live_instr");

        // Branch counters
        wr(BASE + 32'h18, 32'd0);
        for (int i = 0; i < 4; i++) begin
            br_retire  = 1'b1;
            br_correct = (i != 2);
            tick();
        end
        br_retire  = 1'b0;
        br_correct = 1'b0;
        rd(BASE + 32'h1C, BP_EN ? 32'd4 : 32'd0, "br_total");
        rd(BASE + 32'h20, BP_EN ? 32'd3 : 32'd0, "br_correct");

        // Asynchronous reset mid-run
        wr(BASE + 32'h30, 32'd1);
        rd(BASE + 32'h10, 32'd7, "pre_reset_cycle");
        #3;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_rdata", mmio_rdata, 32'd0);
        check("midrun_reset_mode", {30'd0, cntr_mode}, 32'd0);
        tick();
        rst_n = 1'b1;
        rd(BASE + 32'h10, 32'd0, "post_reset_cycle");
        rd(BASE + 32'h14, 32'd0, "post_reset_instr");
        rd(BASE + 32'h3C, 32'd0, "post_reset_snap");
        rd(BASE + 32'h34, 32'd0, "post_reset_status");

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
